// File: rtl/mp_pkg.sv
// Shared sizing and controller state encoding for the 3072-bit multiplier datapath.
package mp_pkg;
    localparam int SIZE   = 3072;
    localparam int RADIX  = 78;
    localparam int DIGITS = (SIZE + RADIX - 1) / RADIX;
    localparam int ACC_W  = SIZE + RADIX + 3;
    localparam int P_W    = 2 * SIZE + 2;

    typedef enum logic [2:0] {IDLE, ISSUE, GUARD, WAIT, ACC, FIN} state_t;
endpackage

// File: rtl/acc_add3.sv
// Three-input accumulator adder; isolated so a CSA+CPA or pipelined adder can drop in.
module acc_add3 #(
    parameter int W    = 3153,
    parameter int IN_W = 3152
) (
    input  logic [W-1:0]    x,
    input  logic [IN_W-1:0] y,
    input  logic [IN_W-1:0] z,
    output logic [W-1:0]    s
);
    assign s = x + W'(y) + W'(z);
endmodule

// File: rtl/outer_loop_acc.sv
// Digit-serial controller around inner_loop_new: issues radix digits of b and
// folds each carry-save result into a right-shifting accumulator.
module outer_loop_acc #(
    parameter int Size   = mp_pkg::SIZE,
    parameter int radix  = mp_pkg::RADIX,
    parameter int DIGITS = (Size + radix - 1) / radix,
    parameter int ACC_W  = Size + radix + 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [Size+1:0]       a,
    input  logic [Size-1:0]       b,
    output logic                  busy,
    output logic                  done,
    output logic [2*Size+1:0]     p,
    output logic [Size+1:0]       il_a,
    output logic [radix-1:0]      il_bi,
    output logic                  il_en,
    input  logic [Size+radix+1:0] il_r0,
    input  logic [Size+radix+1:0] il_r1,
    input  logic                  il_en_out
);
    import mp_pkg::*;

    localparam int IDX_W = $clog2(DIGITS + 1);
    localparam int LO_W  = radix * DIGITS;
    localparam int R_W   = Size + radix + 2;
    localparam int PW    = 2 * Size + 2;

    state_t             state;
    logic [LO_W-1:0]    b_reg;
    logic [ACC_W-1:0]   acc;
    logic [LO_W-1:0]    lo;
    logic [IDX_W-1:0]   idx;
    logic [R_W-1:0]     r0_q, r1_q;
    logic [ACC_W-1:0]   s;
    logic [ACC_W-1:0]   acc_nxt;
    logic [LO_W-1:0]    lo_nxt;

    acc_add3 #(.W(ACC_W), .IN_W(R_W)) u_add (
        .x(acc),
        .y(r0_q),
        .z(r1_q),
        .s(s)
    );

    // Low radix bits of each pass are final; they retire into lo from the top.
    assign acc_nxt = s >> radix;
    assign lo_nxt  = {s[radix-1:0], lo[LO_W-1:radix]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            il_en <= 1'b0;
            p     <= '0;
            il_a  <= '0;
            il_bi <= '0;
            b_reg <= '0;
            acc   <= '0;
            lo    <= '0;
            idx   <= '0;
            r0_q  <= '0;
            r1_q  <= '0;
        end else begin
            il_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        il_a  <= a;
                        b_reg <= LO_W'(b);
                        acc   <= '0;
                        lo    <= '0;
                        idx   <= '0;
                        il_bi <= b[radix-1:0];
                        il_en <= 1'b1;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: state <= GUARD;
                // The inner loop still shows last pass's valid here; skip it.
                GUARD: state <= WAIT;
                WAIT: begin
                    if (il_en_out) begin
                        r0_q  <= il_r0;
                        r1_q  <= il_r1;
                        state <= ACC;
                    end
                end
                ACC: begin
                    acc <= acc_nxt;
                    lo  <= lo_nxt;
                    idx <= idx + 1'b1;
                    if (idx == IDX_W'(DIGITS - 1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        p     <= PW'({acc_nxt, lo_nxt});
                        state <= FIN;
                    end else begin
                        il_bi <= b_reg[(int'(idx) + 1) * radix +: radix];
                        il_en <= 1'b1;
                        state <= ISSUE;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
